// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory and
// fills the IF/ID register, with stall, redirect/flush and self-halt handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS    = 256,
    parameter int unsigned HALT_ZERO_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_memread,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [32:0] MemBytes    = 33'(IMEM_WORDS) << 2;
    localparam logic [31:0] LastPc      = 32'((IMEM_WORDS - 1) * 4);
    localparam logic [4:0]  ZeroRunHalt = 5'(HALT_ZERO_RUN);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [4:0]  zero_run_q;

    logic [31:0] target;
    logic        target_ok;
    logic [4:0]  zero_run_next;
    logic        unused_redirect_lsb;

    // Redirect targets are forced word aligned; the low bits are deliberately dropped.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        target        = {redirect_pc[31:2], 2'b00};
        target_ok     = {1'b0, target} < MemBytes;
        zero_run_next = (imem_readdata == 32'h0) ? zero_run_q + 5'd1 : 5'd0;
    end

    assign imem_address = pc_q;
    assign imem_memread = (state_q == StFetch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            zero_run_q    <= 5'd0;
            fetch_count   <= 16'd0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= 32'h0;
            ifid_pc       <= 32'h0;
            ifid_pc_plus4 <= 32'h0;
            halted        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                end
                StFetch: begin
                    if (redirect_valid) begin
                        // Flush the wrong-path word; an out-of-range target stops fetch.
                        ifid_valid <= 1'b0;
                        zero_run_q <= 5'd0;
                        if (target_ok) begin
                            pc_q <= target;
                        end else begin
                            state_q <= StHalt;
                            halted  <= 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_instr    <= imem_readdata;
                        ifid_pc       <= pc_q;
                        ifid_pc_plus4 <= pc_q + 32'd4;
                        ifid_valid    <= 1'b1;
                        zero_run_q    <= zero_run_next;
                        pc_q          <= pc_q + 32'd4;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                        if (zero_run_next == ZeroRunHalt || pc_q == LastPc) begin
                            state_q <= StHalt;
                            halted  <= 1'b1;
                        end
                    end
                end
                StHalt: begin
                    ifid_valid <= 1'b0;
                    if (redirect_valid && target_ok) begin
                        pc_q       <= target;
                        zero_run_q <= 5'd0;
                        halted     <= 1'b0;
                        state_q    <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
